// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the serial instruction-memory loader.
// Optional trailer checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  // FSM encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LEN_HI = 3'd1;
  localparam state_t S_LEN_LO = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_CHK    = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam state_t S_ERR    = 3'd6;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 7
);
  // rx handshake: a byte transfers on every clock edge where rx_valid && rx_ready;
  // rx_data must be stable while rx_valid is high, and rx_ready never waits on rx_valid.
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Shifts bytes in MSB-first and flags the byte that completes a 32-bit word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The completing byte is passed straight through so the word is ready in the same cycle.
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: length-prefixed big-endian image, CPU held in reset
// until a full image is written. Define IMEM_LOADER_CHECKSUM_EN for the sum trailer byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS      = 128,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_req,
  imem_loader_if.master   bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err,
  output state_t          state_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [LEN_W-1:0]   n_q, n_d, idx_q, idx_d;
  logic [LEN_W-1:0]   new_len;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               req_low_q, req_low_d;
  logic               rx_ready_q, we_q, hold_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [31:0]        wdata_q;
  logic               accept, loading, wa_clr, wa_byte;
  logic [31:0]        wa_word;
  logic               wa_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  assign loading = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK};
  assign accept  = bus.rx_valid && rx_ready_q;
  assign new_len = {len_hi_q, bus.rx_data};
  assign wa_byte = accept && (state_q == S_DATA);
  assign wa_clr  = (state_d == S_LEN_HI) && (state_q != S_LEN_HI);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (wa_clr),
    .byte_valid_i (wa_byte),
    .byte_i       (bus.rx_data),
    .word_o       (wa_word),
    .word_valid_o (wa_valid)
  );

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    n_d       = n_q;
    idx_d     = idx_q;
    req_low_d = req_low_q;
    case (state_q)
      S_IDLE: if (load_req) begin
        state_d = S_LEN_HI;
        idx_d   = '0;
      end
      S_LEN_HI: if (accept) begin
        len_hi_d = bus.rx_data;
        state_d  = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        n_d = new_len;
        if (new_len == '0 || new_len > LEN_W'(MEM_WORDS)) state_d = S_ERR;
        else                                                state_d = S_DATA;
      end
      S_DATA: if (wa_valid) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == n_q - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERR;
`endif
      S_DONE: state_d = S_IDLE;
      // A restart from ERR needs a fresh rising level on load_req.
      S_ERR: begin
        if (!load_req) begin
          req_low_d = 1'b1;
        end else if (req_low_q) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (loading && !accept && tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) state_d = S_ERR;
    if (state_d == S_ERR && state_q != S_ERR) req_low_d = 1'b0;

    tmr_d = '0;
    if (loading && !accept && state_d == state_q) tmr_d = tmr_q + 1'b1;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_comb begin
    sum_d = sum_q;
    if (wa_clr)       sum_d = '0;
    else if (wa_byte) sum_d = sum_q + bus.rx_data;
  end
`endif

  // Flags are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      req_low_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      req_low_q  <= req_low_d;
      rx_ready_q <= state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK};
      we_q       <= wa_valid;
      if (wa_valid) begin
        waddr_q <= idx_q[ADDR_W-1:0];
        wdata_q <= wa_word;
      end
      hold_q     <= state_d != S_IDLE;
      busy_q     <= state_d != S_IDLE;
      done_q     <= state_d == S_DONE;
      err_q      <= state_d == S_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as bytes are sent and
// a negedge monitor pops them. Checksum-specific cases build with IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int MEM_WORDS = 128;
  localparam int ADDR_W    = 7;
  localparam int TMO       = 40;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic DONE_ON_LAST = 1'b0;
`else
  localparam logic DONE_ON_LAST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_req = 1'b0;
  logic       cpu_hold, busy, done, err;
  logic [2:0] dbg_state;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .MEM_WORDS      (MEM_WORDS),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load_req (load_req),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];          // {done, addr, data}
  logic [31:0] img[MEM_WORDS];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, done, bus.mem_waddr, bus.mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("ram_write", {24'd0, done, bus.mem_waddr, bus.mem_wdata}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int guard;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    guard = 0;
    while (!bus.rx_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic start_load();
    load_req = 1'b0;
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Sends a full image from img[0..n-1], queues the writes, and checks the completion.
  task automatic load_image(input int n);
    int d0;
    logic [7:0] sum;
    d0  = done_cnt;
    sum = 8'h00;
    start_load();
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({(w == n - 1) ? DONE_ON_LAST : 1'b0, 7'(w), img[w]});
      for (int b = 0; b < 4; b++) begin
        sum = sum + img[w][31-8*b -: 8];
        send_byte(img[w][31-8*b -: 8]);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(sum);
    check("csum_done_pulse", 64'(done), 64'd1);
`endif
    @(posedge clk); #1;
    check("hold_after_done", 64'(cpu_hold), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic bad_len(input logic [7:0] lo);
    start_load();
    send_byte(8'h00);
    send_byte(lo);
    check("len_err", 64'(err), 64'd1);
    check("len_err_hold", 64'(cpu_hold), 64'd1);
    check("len_err_ready", 64'(bus.rx_ready), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    logic [31:0] word;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_waddr", 64'(bus.mem_waddr), 64'd0);
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_flags", {60'd0, cpu_hold, busy, done, err}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // nominal two-word image
    img[0] = 32'h2008_003F;
    img[1] = 32'hAC08_0000;
    load_image(2);

    // length bounds: zero and MEM_WORDS+1 both rejected before any write
    bad_len(8'h00);
    bad_len(8'h81);

    // largest legal image
    for (int i = 0; i < MEM_WORDS; i++)
      img[i] = {8'(i), 8'(~i), 8'hA5, 8'(i * 3)};
    load_image(MEM_WORDS);

    // timeout after byte 3 of the first word
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (TMO - 1) begin
      @(posedge clk); #1;
    end
    check("tmo_not_yet", 64'(err), 64'd0);
    @(posedge clk); #1;
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_hold", 64'(cpu_hold), 64'd1);
    img[0] = 32'hDEAD_BEEF;
    load_image(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // good trailer is covered by load_image; check a bad trailer keeps the CPU held
    d0 = done_cnt;
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    exp_q.push_back({1'b0, 7'd0, 32'h0102_0304});
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h0B);
    check("csum_bad_err", 64'(err), 64'd1);
    check("csum_bad_hold", 64'(cpu_hold), 64'd1);
    @(posedge clk); #1;
    check("csum_bad_no_done", 64'(done_cnt - d0), 64'd0);
    img[0] = 32'h0102_0304;
    load_image(1);
`endif

    // backpressure then reset during word 5
    start_load();
    send_byte(8'h00);
    send_byte(8'h06);
    for (int w = 0; w < 5; w++) begin
      word = {8'h10 + 8'(w), 8'h20 + 8'(w), 8'h30 + 8'(w), 8'h40 + 8'(w)};
      if (w < 4) exp_q.push_back({1'b0, 7'(w), word});
      for (int b = 0; b < ((w < 4) ? 4 : 2); b++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          check("ready_in_data", 64'(bus.rx_ready), 64'd1);
        end
        send_byte(word[31-8*b -: 8]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hold", 64'(cpu_hold), 64'd0);
    check("midrst_we", 64'(bus.mem_we), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader for the single-cycle CPU's instruction memory, an instruction RAM that replaces the hard-coded program store. It accepts a byte stream from the UART receiver, assembles 32-bit big-endian instruction words, and writes them sequentially from word 0. It holds the CPU in reset while loading and releases it only after a complete, valid image has been written. Typical use: reprogram the board without resynthesis.

## Interface
- `MEM_WORDS`, 128: instruction memory depth in words. Legal image lengths are 1..MEM_WORDS.
- `ADDR_W`, 7: word-address width. Must satisfy 2^ADDR_W >= MEM_WORDS.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle gap between bytes while loading.

- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-low.
- `load_req` in 1: level; starts a load when sampled high in IDLE.
- `rx_data` in 8: byte from the UART receiver.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader can accept a byte.
- `mem_we` out 1: instruction RAM write strobe.
- `mem_waddr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: instruction word to write.
- `cpu_hold` out 1: CPU reset request, active high.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse when a load completes successfully.
- `err` out 1: sticky error flag.

## Operation
- Image format: LEN_HI, LEN_LO (16-bit word count N, MSB first), then N words of 4 bytes each, MSB first. An optional trailer follows; see Configuration.
- States and transitions:
  - IDLE, entered after reset: `load_req`=1 -> LEN_HI. Clears `err` and the word index; asserts `cpu_hold`.
  - LEN_HI -> LEN_LO on byte accept.
  - LEN_LO: on byte accept, if N==0 or N>MEM_WORDS -> ERR, else -> DATA.
  - DATA: bytes are shifted into the word register. On each 4th byte the word is written to the current index and the index increments. After the Nth word -> CHK if the macro is defined, else DONE.
  - CHK: on byte accept, a match -> DONE, a mismatch -> ERR.
  - DONE: lasts one cycle, then -> IDLE.
  - ERR: `err`=1 and `cpu_hold`=1, held until `load_req` is low for at least one cycle and then high again. That re-request -> LEN_HI.
- A byte is accepted on any cycle with `rx_valid && rx_ready`. `rx_ready`=1 only in LEN_HI, LEN_LO, DATA and CHK.
- Timeout: the counter clears on every accepted byte and on every state entry. It counts cycles in LEN_HI through CHK. Reaching TIMEOUT_CYCLES -> ERR.
- `load_req` is ignored outside IDLE and ERR.
- Reset mid-load: the loader goes to IDLE and `cpu_hold` drops. Words already written remain in RAM and the rest of RAM is unspecified; software must reload.
- Byte count is 4*N. The word index wraps never, because N <= MEM_WORDS is checked before DATA.

## Timing
- Reset values: `rx_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are registered.
- `mem_we`=1 for exactly the one cycle after the edge that accepts the 4th byte of a word. `mem_waddr` and `mem_wdata` are valid in that same cycle.
- `busy`=1 in every state except IDLE.
- `cpu_hold`=1 from the cycle after `load_req` is accepted through the DONE cycle. It falls in the first cycle of IDLE.
- Without checksum: `done` coincides with the final `mem_we` cycle.
- With checksum: `done` pulses one cycle after the checksum byte is accepted.
- Sustained throughput is one byte per clock.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- Defined: one trailer byte follows the image. It must equal the sum mod 256 of all 4N data bytes (the length bytes are excluded). A mismatch -> ERR, and the CPU stays held.
- Undefined: there is no trailer and the CHK state does not exist. The transition after the last word goes to DONE.

## Structure
- Package `imem_loader_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR);
  - the 16-bit length width constant;
  - the byte-per-word constant (4).
- One sub-module, `word_assembler`:
  - shifts in bytes MSB-first;
  - has a 2-bit byte counter and a `word_valid` output;
  - has a synchronous clear.
- The FSM, timeout counter and checksum accumulator live in the top level.

## Test plan
- **Nominal load, checksum off.** Send 00 02, then 20 08 00 3F, then AC 08 00 00. Expect two writes, `addr0`=0x2008003F and `addr1`=0xAC080000. `done` pulses in the same cycle as the second `mem_we`, and `cpu_hold` falls on the next cycle.
- **Length bounds.** Lengths 00 00 and 00 81 -> `err`=1 after LEN_LO, with no `mem_we`. Length 00 80 followed by 512 bytes -> 128 writes, last `mem_waddr`=127, `done`.
- **Timeout.** Stop sending after byte 3 of the first word. Exactly TIMEOUT_CYCLES later, `err`=1, `cpu_hold`=1, and no `mem_we` has occurred. Drop `load_req`, re-raise it, and a full reload succeeds.
- **Checksum, with `IMEM_LOADER_CHECKSUM_EN`.** Use image 00 01 01 02 03 04. Trailer 0A -> `done`. Trailer 0B -> `err`, with the word still written to addr 0.
- **Backpressure and reset mid-load.** Toggle `rx_valid` randomly: `rx_ready` stays 1 in DATA and the data assembles correctly. Assert `reset` low during word 5: next cycle `busy`=0, `cpu_hold`=0, `mem_we`=0.
